event_blinker: RTL and testbench
================================

EVENT_BLINKER -- requirements
Module: event_blinker

Interface
REQ-001 SHALL have parameter TICK_VAL, default 28'h3D0900: prescaler terminal count; one tick every TICK_VAL+1 clk cycles.
REQ-002 SHALL have parameter ON_TICKS, default 4: LED-on duration per blink, in ticks (>=1).
REQ-003 SHALL have parameter OFF_TICKS, default 4: LED-off gap after each blink, in ticks (>=1).
REQ-004 SHALL have parameter PEND_W, default 4: width of the pending-event counter.
REQ-005 SHALL have port clk  input  1  system clock; all logic on posedge clk.
REQ-006 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-007 SHALL have port event_pulse  input  1  one-clk event strobe, e.g. a debounced button pulse; each high cycle is one event.
REQ-008 SHALL have port led_out  output  1  registered LED drive; high only in state ON.
REQ-009 SHALL have port busy  output  1  high in ON or OFF.
REQ-010 SHALL have port pend_cnt  output  PEND_W  events accepted but not yet blinked.
REQ-011 SHALL have port overflow  output  1  sticky; set when an event is dropped at saturation.

Function
REQ-012 SHALL implement FSM states IDLE, ON, OFF; all outputs registered.
REQ-013 Prescaler SHALL be held at 0 in IDLE, count 0..TICK_VAL in ON/OFF, and assert tick for one clk at TICK_VAL before wrapping to 0.
REQ-014 Prescaler and tick counter SHALL clear on every state transition, so ON lasts exactly ON_TICKS*(TICK_VAL+1) clk and OFF lasts exactly OFF_TICKS*(TICK_VAL+1) clk.
REQ-015 IDLE -> ON when event_pulse=1 or pend_cnt>0; a pending event is consumed first if present; led_out rises the clk after the event cycle (latency 1).
REQ-016 ON -> OFF on the ON_TICKS-th tick.
REQ-017 OFF -> ON on the OFF_TICKS-th tick if pend_cnt>0 or event_pulse=1 that cycle, consuming one event; otherwise OFF -> IDLE.
REQ-018 An event_pulse not consumed in the same cycle SHALL increment pend_cnt.
REQ-019 Simultaneous event_pulse and consumption of a pending event SHALL leave pend_cnt unchanged.
REQ-020 At pend_cnt = 2^PEND_W-1, a further unconsumed event SHALL be dropped, pend_cnt SHALL hold, and overflow SHALL set.
REQ-021 overflow SHALL clear only on rst.
REQ-022 Each accepted event SHALL produce exactly one ON interval; events are never merged or retriggered into a longer ON.

Reset
REQ-023 On rst=1 at a clock edge: state=IDLE, led_out=0, busy=0, pend_cnt=0, overflow=0, prescaler=0, tick counter=0.
REQ-024 rst mid-blink SHALL abort immediately; pending events are discarded.
REQ-025 event_pulse in the same cycle as rst SHALL be ignored.
REQ-026 No state SHALL depend on initial values without reset.

Structure
REQ-027 State encodings and default parameter values SHALL live in shared package event_blinker_pkg.
REQ-028 The prescaler SHALL be sub-module tick_gen (inputs clk, rst, clr, en; output tick), reusable by other IO blocks.
REQ-029 The FSM, tick counter and pending counter SHALL reside in event_blinker.

Verification (TICK_VAL=3, ON_TICKS=2, OFF_TICKS=1, PEND_W=2: ON=8 clk, OFF=4 clk)
REQ-030 Single pulse at cycle 10 -> led_out=1 for cycles 11-18, 0 for 19-22; busy=0 from cycle 23; pend_cnt stays 0.
REQ-031 Pulses at cycles 10 and 13 -> pend_cnt=1 at cycle 14; two blinks, led_out high 11-18 and 23-30; pend_cnt=0 from cycle 23.
REQ-032 Five pulses during the first ON interval -> pend_cnt saturates at 3, overflow=1; exactly four blinks total; overflow stays 1 afterward.
REQ-033 Event coinciding with the final OFF tick while pend_cnt=0 -> direct OFF->ON with no IDLE cycle; pend_cnt stays 0.
REQ-034 rst at cycle 15 of a blink with pend_cnt=2 -> cycle 16: led_out=0, busy=0, pend_cnt=0, overflow=0; no further blinks.
REQ-035 event_pulse and rst both high at the same edge -> no blink, pend_cnt=0.

Source files
------------

// File: rtl/event_blinker_pkg.sv
// rtl/event_blinker_pkg.sv - shared state encoding and default parameters for event_blinker
package event_blinker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  localparam logic [27:0] DEF_TICK_VAL  = 28'h3D0900;
  localparam int          DEF_ON_TICKS  = 4;
  localparam int          DEF_OFF_TICKS = 4;
  localparam int          DEF_PEND_W    = 4;
  localparam int          TICK_CNT_W    = 16;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - prescaler emitting a one-clk tick every TICK_VAL+1 enabled cycles
module tick_gen
  import event_blinker_pkg::*;
#(
  parameter logic [27:0] TICK_VAL = DEF_TICK_VAL
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  logic [27:0] count;

  // Held at zero whenever disabled so a fresh enable always starts a full period
  always_ff @(posedge clk) begin
    if (rst || clr || !en) begin
      count <= '0;
    end else if (count == TICK_VAL) begin
      count <= '0;
    end else begin
      count <= count + 28'd1;
    end
  end

  assign tick = en && (count == TICK_VAL);

endmodule

// File: rtl/event_blinker.sv
// rtl/event_blinker.sv - blinks an LED once per accepted event, queuing events that arrive while busy
module event_blinker
  import event_blinker_pkg::*;
#(
  parameter logic [27:0] TICK_VAL  = DEF_TICK_VAL,
  parameter int          ON_TICKS  = DEF_ON_TICKS,
  parameter int          OFF_TICKS = DEF_OFF_TICKS,
  parameter int          PEND_W    = DEF_PEND_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              event_pulse,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              overflow
);

  localparam logic [TICK_CNT_W-1:0] ON_LAST  = TICK_CNT_W'(ON_TICKS - 1);
  localparam logic [TICK_CNT_W-1:0] OFF_LAST = TICK_CNT_W'(OFF_TICKS - 1);
  localparam logic [PEND_W-1:0]     PEND_MAX = '1;

  state_t                  state;
  state_t                  state_next;
  logic [TICK_CNT_W-1:0]   tick_cnt;
  logic                    tick;
  logic                    state_change;
  logic                    go_on;
  logic                    pend_nz;
  logic                    pend_inc;
  logic                    pend_dec;

  assign state_change = (state_next != state);

  tick_gen #(
    .TICK_VAL (TICK_VAL)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_change),
    .en   (state != ST_IDLE),
    .tick (tick)
  );

  always_comb begin
    state_next = state;
    go_on      = 1'b0;
    pend_nz    = (pend_cnt != '0);
    case (state)
      ST_IDLE: begin
        if (event_pulse || pend_nz) begin
          state_next = ST_ON;
          go_on      = 1'b1;
        end
      end
      ST_ON: begin
        if (tick && (tick_cnt == ON_LAST)) begin
          state_next = ST_OFF;
        end
      end
      ST_OFF: begin
        if (tick && (tick_cnt == OFF_LAST)) begin
          if (event_pulse || pend_nz) begin
            state_next = ST_ON;
            go_on      = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A new blink takes the oldest pending event first; the live pulse is queued instead
  assign pend_dec = go_on && pend_nz;
  assign pend_inc = event_pulse && (!go_on || pend_nz);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      led_out  <= 1'b0;
      busy     <= 1'b0;
      tick_cnt <= '0;
      pend_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      state   <= state_next;
      led_out <= (state_next == ST_ON);
      busy    <= (state_next != ST_IDLE);

      if (state_change) begin
        tick_cnt <= '0;
      end else if (tick) begin
        tick_cnt <= tick_cnt + 1'b1;
      end

      if (pend_inc && !pend_dec) begin
        if (pend_cnt == PEND_MAX) begin
          overflow <= 1'b1;
        end else begin
          pend_cnt <= pend_cnt + 1'b1;
        end
      end else if (pend_dec && !pend_inc) begin
        pend_cnt <= pend_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_event_blinker.sv
// tb/tb_event_blinker.sv - scoreboard bench for event_blinker against a timeline reference model
module tb_event_blinker;

  localparam int TV      = 3;
  localparam int ON_T    = 2;
  localparam int OFF_T   = 1;
  localparam int PW      = 2;
  localparam int ON_LEN  = (TV + 1) * ON_T;
  localparam int OFF_LEN = (TV + 1) * OFF_T;
  localparam int PMAX    = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          event_pulse = 1'b0;
  logic          led_out;
  logic          busy;
  logic [PW-1:0] pend_cnt;
  logic          overflow;

  event_blinker #(
    .TICK_VAL  (28'(TV)),
    .ON_TICKS  (ON_T),
    .OFF_TICKS (OFF_T),
    .PEND_W    (PW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .event_pulse (event_pulse),
    .led_out     (led_out),
    .busy        (busy),
    .pend_cnt    (pend_cnt),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic led;
    logic bsy;
    int   pend;
    logic ovf;
  } status_t;

  status_t exp_q[$];
  int      blink_q[$];
  int      cyc = 0;
  int      n_cmp = 0;
  int      n_fail = 0;

  // Model: a blink occupies [start, start+ON_LEN+OFF_LEN-1]; busy_until is its last OFF cycle
  int      m_pend = 0;
  logic    m_ovf = 1'b0;
  int      m_busy_until = -1;
  int      m_start = -100;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic e, input logic r);
    status_t s;
    int c;
    @(negedge clk);
    event_pulse = e;
    rst = r;
    c = cyc;
    if (r) begin
      m_pend = 0;
      m_ovf = 1'b0;
      m_busy_until = -1;
      m_start = -100;
    end else if (c >= m_busy_until && (m_pend > 0 || e)) begin
      m_start = c + 1;
      m_busy_until = c + ON_LEN + OFF_LEN;
      blink_q.push_back(c + 1);
      if (m_pend > 0 && !e) m_pend--;
    end else if (e) begin
      if (m_pend == PMAX) m_ovf = 1'b1;
      else m_pend++;
    end
    s.led  = (c + 1 >= m_start) && (c + 1 < m_start + ON_LEN);
    s.bsy  = (c + 1 <= m_busy_until);
    s.pend = m_pend;
    s.ovf  = m_ovf;
    exp_q.push_back(s);
  endtask

  task automatic run_pattern(input int len, input logic [31:0] mask, input int rst_at);
    for (int k = 0; k < len; k++) begin
      step((k < 32) ? mask[k] : 1'b0, k == rst_at);
    end
  endtask

  initial begin : monitor
    status_t s;
    logic prev_led;
    prev_led = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        s = exp_q.pop_front();
        chk("led_out", 32'(led_out), 32'(s.led));
        chk("busy", 32'(busy), 32'(s.bsy));
        chk("pend_cnt", 32'(pend_cnt), 32'(s.pend));
        chk("overflow", 32'(overflow), 32'(s.ovf));
      end
      if (led_out === 1'b1 && prev_led !== 1'b1) begin
        if (blink_q.size() == 0) begin
          chk("unexpected_blink", 32'(cyc), 32'hFFFF_FFFF);
        end else begin
          chk("blink_start", 32'(cyc), 32'(blink_q.pop_front()));
        end
      end
      prev_led = led_out;
    end
  end

  initial begin : stimulus
    repeat (3) step(1'b0, 1'b1);
    run_pattern(20, 32'h1, -1);
    run_pattern(30, 32'h9, -1);
    run_pattern(60, 32'h7D, -1);
    step(1'b0, 1'b1);
    run_pattern(30, 32'h1001, -1);
    run_pattern(20, 32'hD, 5);
    run_pattern(10, 32'h1, 0);
    run_pattern(20, 32'h0, -1);
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(5) == 0, $urandom_range(199) == 0);
    end
    run_pattern(30, 32'h0, -1);
    @(posedge clk);
    #2;
    chk("blinks_drained", 32'(blink_q.size()), 32'd0);
    chk("status_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
